// File: rtl/pd_rx_buffer.sv
// rtl/pd_rx_buffer.sv - photodetector receive ejection FIFO with credit return and overflow drop flags
// Optional feature macro RX_DROP_CNT_EN: saturating 16-bit drop counter on drop_count.
package pd_rx_pkg;
    typedef struct packed {
        logic [7:0]  id;
        logic [23:0] payload;
    } packet_t;
endpackage

module pd_rx_buffer
    import pd_rx_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  packet_t                    in_data,
    input  logic                       in_valid,
    output packet_t                    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       credit_out,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_pulse,
    output logic [15:0]                drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

    packet_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          credit_q, credit_d;
    logic          drop_pulse_q, drop_pulse_d;
    logic          push, pop, drop;

    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_LVL);
    assign credit_out  = credit_q;
    assign drop_pulse  = drop_pulse_q;

    // A pop frees a slot in the same cycle, so a full queue still accepts when draining.
    always_comb begin
        pop          = out_valid & out_ready;
        push         = in_valid & ((count_q < FULL_LVL) | pop);
        drop         = in_valid & ~push;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        credit_d     = pop;
        drop_pulse_d = drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credit_q     <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            credit_q     <= credit_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage carries no reset; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= 16'h0000;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 16'h0000;
`endif

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= FULL_LVL);
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_data == $past(out_data)));
`endif
endmodule

// File: tb/tb_pd_rx_buffer.sv
// tb/tb_pd_rx_buffer.sv - scoreboard bench for pd_rx_buffer against a queue-based reference model
module tb_pd_rx_buffer;
    import pd_rx_pkg::*;

    localparam int DEPTH        = 8;
    localparam int AFULL_MARGIN = 2;

    logic       clk = 1'b0;
    logic       rst;
    packet_t    in_data;
    logic       in_valid;
    packet_t    out_data;
    logic       out_valid;
    logic       out_ready;
    logic       credit_out;
    logic       almost_full;
    logic [3:0] count;
    logic       drop_pulse;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    // Reference model state: expected packet order plus occupancy and pending pulses.
    packet_t exp_q[$];
    int      occ       = 0;
    int      drops     = 0;
    bit      prev_pop  = 0;
    bit      prev_drop = 0;
    int      credits   = 0;

    pd_rx_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .credit_out(credit_out), .almost_full(almost_full), .count(count),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_drop_count();
`ifdef RX_DROP_CNT_EN
        return (drops > 65535) ? 65535 : drops;
`else
        return 0;
`endif
    endfunction

    // Model: checks control outputs, then applies this cycle's spec rules to predict the next.
    always @(negedge clk) begin
        if (!rst) begin
            bit pop_m, push_m;
            check("count", 32'(count), 32'(occ));
            check("out_valid", 32'(out_valid), 32'(occ != 0));
            check("almost_full", 32'(almost_full), 32'(occ >= DEPTH - AFULL_MARGIN));
            check("credit_out", 32'(credit_out), 32'(prev_pop));
            check("drop_pulse", 32'(drop_pulse), 32'(prev_drop));
            check("drop_count", 32'(drop_count), 32'(exp_drop_count()));
            if (credit_out) credits++;
            pop_m  = (occ != 0) && out_ready;
            push_m = in_valid && ((occ < DEPTH) || pop_m);
            if (push_m) exp_q.push_back(in_data);
            occ       = occ + int'(push_m) - int'(pop_m);
            prev_pop  = pop_m;
            prev_drop = in_valid && !push_m;
            if (prev_drop) drops++;
        end
    end

    // Monitor: head of the scoreboard must be presented whenever out_valid is high.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic iv, input logic [7:0] id, input logic rdy);
        in_valid = iv;
        in_data  = '{id: id, payload: 24'($urandom)};
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int pushed;
        int cyc;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_credit", 32'(credit_out), 0);
        check("rst_drop_pulse", 32'(drop_pulse), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        rst = 1'b0;

        // Basic flow
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1);
        repeat (5) step(1'b0, 8'h0, 1'b1);
        check("basic_credits", 32'(credits), 3);

        // Fill with stall, then overflow
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        check("fill_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b0, 8'h0, 1'b0);
        check("overflow_count", 32'(count), 32'(DEPTH));
`ifdef RX_DROP_CNT_EN
        check("overflow_drop_count", 32'(drop_count), 3);
`else
        check("overflow_drop_count", 32'(drop_count), 0);
`endif

        // Full with simultaneous pop and push
        step(1'b1, 8'h30, 1'b1);
        check("full_popush_count", 32'(count), 32'(DEPTH));
        check("full_popush_nodrop", 32'(drop_pulse), 0);
        repeat (DEPTH + 3) step(1'b0, 8'h0, 1'b1);

        // Wrap-around with random out_ready
        pushed = 0;
        cyc = 0;
        while (pushed < 20 && cyc < 400) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, 8'(pushed), 1'($urandom_range(0, 3) != 0));
                pushed++;
            end else begin
                step(1'b0, 8'h0, 1'($urandom_range(0, 3) != 0));
            end
            cyc++;
        end
        repeat (DEPTH + 3) step(1'b0, 8'h0, 1'b1);

        // Random traffic biased towards overflow
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 4));
        repeat (DEPTH + 3) step(1'b0, 8'h0, 1'b1);

        // Async reset mid-stream with five queued packets
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        check("pre_reset_count", 32'(count), 5);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_credit", 32'(credit_out), 0);
        check("arst_drop_pulse", 32'(drop_pulse), 0);
        exp_q.delete();
        occ = 0;
        drops = 0;
        prev_pop = 0;
        prev_drop = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 8'h55, 1'b1);
        repeat (4) step(1'b0, 8'h0, 1'b1);

        check("final_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pd_rx_buffer.md
Name: pd_rx_buffer

Overview:
- Receive-side ejection buffer directly downstream of the photodetector stage.
- Absorbs the photodetector's valid-only stream of packet_t. The optical path cannot be stalled, so there is no input backpressure.
- Presents packets to the local network interface with a valid/ready handshake.
- Returns one credit per delivered packet to the upstream flow-control logic, and flags overflow drops.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AFULL_MARGIN, 2, almost_full asserts when occupancy >= DEPTH - AFULL_MARGIN; range 0..DEPTH-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  packet_t  packet from photodetector
- in_valid  input  1  in_data valid this cycle; no ready path back
- out_data  output  packet_t  head-of-queue packet
- out_valid  output  1  queue non-empty
- out_ready  input  1  consumer accepts out_data this cycle
- credit_out  output  1  one-cycle pulse per delivered packet
- almost_full  output  1  occupancy >= DEPTH - AFULL_MARGIN
- count  output  $clog2(DEPTH+1)  current occupancy
- drop_pulse  output  1  one-cycle pulse after a dropped packet
- drop_count  output  16  saturating drop counter (see Optional Feature)

Behaviour:
- Storage:
  - DEPTH-entry array; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally at DEPTH-1 -> 0.
  - Occupancy is held in count, not derived from pointers.
- Reset (async):
  - wr_ptr=0, rd_ptr=0, count=0, credit_out=0, drop_pulse=0, drop_count=0.
  - Hence out_valid=0 and almost_full=0 (AFULL_MARGIN<DEPTH).
  - Array contents are don't-care; out_data is don't-care while out_valid=0.
- pop = out_valid & out_ready.
- push = in_valid & (count < DEPTH | pop).
  - When full and popping in the same cycle, the incoming packet is accepted into the freed slot.
- drop = in_valid & ~push, i.e. full with no pop.
  - The packet is discarded; no state changes except the drop signals.
- count update per cycle:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Output side is first-word fall-through:
  - out_valid = (count != 0); out_data = mem[rd_ptr] (combinational read of the head).
  - Latency: a packet pushed at edge N is visible on out_data/out_valid in the cycle after edge N.
  - Same-cycle push and pop on an empty queue is impossible: out_valid=0, so pop=0.
- out_data must hold stable while out_valid=1 and out_ready=0.
- credit_out:
  - Registered; 1 in the cycle after each pop, else 0.
  - Back-to-back pops give a continuous high, one credit per cycle.
- drop_pulse: registered; 1 in the cycle after each drop.
- almost_full: combinational from count.
- Ordering: strict FIFO; no reordering, no duplication.
- Reset mid-operation: queued packets are lost; no credits are issued for them. Upstream re-initialises its credits on the same reset.
- Assertions (sim only):
  - count never exceeds DEPTH.
  - out_data is stable under stall.

Optional Feature:
- Macro: RX_DROP_CNT_EN.
- Defined:
  - drop_count increments by 1 on every cycle with drop=1, saturating at 16'hFFFF (no wrap).
  - Cleared only by rst.
- Undefined: drop_count tied to 16'h0000 and no counter register is synthesised. drop_pulse is unaffected either way.

Test Plan:
- Basic flow: out_ready=1; push 3 packets with ids 1,2,3 on consecutive cycles.
  - out_valid rises the cycle after the first push; ids emerge in order 1,2,3.
  - credit_out is high for 3 consecutive cycles, starting one cycle after the first pop; count returns to 0.
- Fill/stall (DEPTH=8, AFULL_MARGIN=2): out_ready=0; push 8 packets.
  - count=8; almost_full asserts after the 6th push.
  - out_data holds packet #1 throughout; credit_out stays 0.
- Overflow: from the full state, push 3 more with out_ready=0.
  - All 3 dropped; drop_pulse high for 3 cycles; count stays 8.
  - With RX_DROP_CNT_EN, drop_count=3; without it, drop_count=0.
- Full + simultaneous pop/push: count=8; out_ready=1 and in_valid=1 in the same cycle.
  - Head popped, new packet accepted, count stays 8, no drop_pulse.
  - The new packet emerges 8th in order.
- Wrap-around: push/pop 20 packets, ids 0..19, with random out_ready.
  - Pointers wrap twice; output sequence is exactly 0..19.
  - Total credit_out pulses=20; drop_count=0.
- Async reset mid-stream: count=5; assert rst between clock edges.
  - out_valid, count, credit_out and drop_pulse go 0 immediately.
  - After deassert, a single push emerges correctly.
